// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use and PC-write stalls,
// branch flushes, and a data-memory wait FSM with a sticky timeout error.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  RA1D,
   input  logic [3:0]  RA2D,
   input  logic [3:0]  RA1E,
   input  logic [3:0]  RA2E,
   input  logic [3:0]  WA3E,
   input  logic [3:0]  WA3M,
   input  logic [3:0]  WA3W,
   input  logic        RegWriteE,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic        MemToRegE,
   input  logic        PCSrcD,
   input  logic        BranchTakenE,
   input  logic        MemReqM,
   input  logic        MemReadyM,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        FlushD,
   output logic        FlushE,
   output logic        MemErr,
   output logic [1:0]  State,
   output logic [15:0] StallCount
);

   typedef enum logic [1:0] {
      StRun   = 2'b00,
      StWait  = 2'b01,
      StError = 2'b10
   } state_e;

   localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);
   localparam logic [3:0] RegPc      = 4'hF;

   state_e      state_q, state_d;
   logic [7:0]  waitcnt_q, waitcnt_d;
   logic        pcs_e_q, pcs_m_q, pcs_w_q;
   logic        mem_err_q;
   logic [15:0] stall_cnt_q;

   logic mem_miss, memwait, ldrstall, pc_wr_pending;
   logic ld_match1, ld_match2;

   // R15 reads the PC, never a forwarded result.
   function automatic logic [1:0] fwd_sel(input logic [3:0] ra, input logic [3:0] wa_m,
                                          input logic [3:0] wa_w, input logic we_m,
                                          input logic we_w);
      logic [1:0] sel;
      sel = 2'b00;
      if (ra != RegPc) begin
         if (we_m && (ra == wa_m))      sel = 2'b10;
         else if (we_w && (ra == wa_w)) sel = 2'b01;
      end
      return sel;
   endfunction

   always_comb begin
      ForwardAE = fwd_sel(RA1E, WA3M, WA3W, RegWriteM, RegWriteW);
      ForwardBE = fwd_sel(RA2E, WA3M, WA3W, RegWriteM, RegWriteW);
   end

   assign ld_match1     = (RA1D == WA3E) && (RA1D != RegPc);
   assign ld_match2     = (RA2D == WA3E) && (RA2D != RegPc);
   assign ldrstall      = MemToRegE & RegWriteE & (ld_match1 | ld_match2);
   assign pc_wr_pending = PCSrcD | pcs_e_q | pcs_m_q;
   assign mem_miss      = MemReqM & ~MemReadyM;
   assign memwait       = (state_q == StWait) | mem_miss | (state_q == StError);

   // A memory wait freezes the whole pipe, so it must also suppress every flush.
   always_comb begin
      StallF = ldrstall | pc_wr_pending | memwait;
      StallD = ldrstall | memwait;
      StallE = memwait;
      StallM = memwait;
      FlushD = (pc_wr_pending | pcs_w_q | BranchTakenE) & ~memwait;
      FlushE = (ldrstall | BranchTakenE) & ~memwait;
   end

   always_comb begin
      state_d   = state_q;
      waitcnt_d = waitcnt_q;
      case (state_q)
         StRun: begin
            if (mem_miss) begin
               state_d   = StWait;
               waitcnt_d = 8'd1;
            end
         end
         StWait: begin
            if (MemReadyM) begin
               state_d   = StRun;
               waitcnt_d = 8'd0;
            end else if (waitcnt_q == TimeoutCnt) begin
               state_d = StError;
            end else begin
               waitcnt_d = waitcnt_q + 8'd1;
            end
         end
         StError: state_d = StError;
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StRun;
         waitcnt_q   <= 8'd0;
         mem_err_q   <= 1'b0;
         pcs_e_q     <= 1'b0;
         pcs_m_q     <= 1'b0;
         pcs_w_q     <= 1'b0;
         stall_cnt_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         waitcnt_q <= waitcnt_d;
         mem_err_q <= mem_err_q | (state_d == StError);
         if (FlushE)       pcs_e_q <= 1'b0;
         else if (!StallE) pcs_e_q <= PCSrcD;
         if (!StallM)      pcs_m_q <= pcs_e_q;
         pcs_w_q <= StallM ? 1'b0 : pcs_m_q;
         if (StallF && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign State      = state_q;
   assign MemErr     = mem_err_q;
   assign StallCount = stall_cnt_q;

endmodule
